// File: rtl/xpb_accumulator.sv
// xpb_accumulator
//   Sums a base addend and NUM_TERMS xpb LUT terms into one ACC_W-bit value.
//   Terms are folded into a carry-save pair (S, C) at one term per cycle.
//   The pair is then resolved into a binary sum, CHUNK bits per cycle.
//   The result is delivered through a valid/ready handshake.
//   No modular correction is applied: sum_out = (base + sum of terms) mod 2^ACC_W.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset; aborts any operation in flight
//   start      begin an operation (sampled in IDLE only)
//   base_in    initial addend, latched on start
//   term_valid term_in is valid this cycle
//   term_ready high while terms are being accepted (ACCUM)
//   term_in    xpb LUT output
//   out_valid  sum_out is valid (DONE)
//   out_ready  consumer accepts sum_out
//   sum_out    resolved sum
//   overflow   a carry was lost beyond ACC_W during this operation
//   busy       operation in progress (state != IDLE)
//
// state   | meaning
// IDLE    | waiting for start
// ACCUM   | folding terms into S/C, one per accepted handshake
// RESOLVE | carry-propagating S+C one chunk per cycle, plus a final overflow cycle
// DONE    | result held until out_ready

module xpb_accumulator #(
  parameter  int WIDTH     = 1024,
  parameter  int GUARD     = 64,
  parameter  int NUM_TERMS = 8,
  parameter  int CHUNK     = 64,
  localparam int ACC_W     = WIDTH + GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base_in,
  input  logic             term_valid,
  output logic             term_ready,
  input  logic [WIDTH-1:0] term_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NUM_CHUNKS = ACC_W / CHUNK;
  localparam int JW = $clog2(NUM_CHUNKS + 1);
  localparam int CW = $clog2(NUM_TERMS + 1);
  localparam logic [JW-1:0] J_LAST   = JW'(NUM_CHUNKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_TERMS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, c_q;
  logic [CW-1:0]    cnt_q;
  logic [JW-1:0]    j_q;
  logic             cy_q;

  logic [ACC_W-1:0] t_ext, maj;
  logic             take, last_term, chunk_phase;
  int               j_idx;
  logic [CHUNK-1:0] s_chunk, c_chunk;
  logic [CHUNK:0]   chunk_sum;

  assign t_ext     = ACC_W'(term_in);
  assign maj       = (s_q & c_q) | (s_q & t_ext) | (c_q & t_ext);
  assign take      = term_valid && (state_q == ACCUM);
  assign last_term = take && (cnt_q == CNT_LAST);

  // RESOLVE spends one extra cycle at j == NUM_CHUNKS to fold the final
  // carry into overflow; the index is clamped so that cycle never reads
  // past the top of S/C.
  assign chunk_phase = (j_q != J_LAST);
  assign j_idx       = chunk_phase ? int'(j_q) : 0;
  assign s_chunk     = s_q[j_idx*CHUNK +: CHUNK];
  assign c_chunk     = c_q[j_idx*CHUNK +: CHUNK];
  assign chunk_sum   = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy_q};

  assign term_ready = (state_q == ACCUM);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (last_term) state_d = RESOLVE;
      RESOLVE: if (!chunk_phase) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      j_q      <= '0;
      cy_q     <= 1'b0;
      sum_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            s_q      <= ACC_W'(base_in);
            c_q      <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
          end
        end
        ACCUM: begin
          if (take) begin
            s_q   <= s_q ^ c_q ^ t_ext;
            c_q   <= maj << 1;
            cnt_q <= cnt_q + CW'(1);
            // The top majority bit is shifted out of C: that carry is lost.
            if (maj[ACC_W-1]) overflow <= 1'b1;
            if (last_term) begin
              j_q  <= '0;
              cy_q <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          if (chunk_phase) begin
            sum_out[j_idx*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
            cy_q <= chunk_sum[CHUNK];
            j_q  <= j_q + JW'(1);
          end else if (cy_q) begin
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_accumulator.sv
module tb_xpb_accumulator;

  localparam int W  = 1024;
  localparam int AW = 1088;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, term_valid, out_ready;
  logic [W-1:0]  base_in, term_in;
  logic          term_ready, out_valid, overflow, busy;
  logic [AW-1:0] sum_out;

  logic          s_start, s_tv, s_ordy;
  logic [63:0]   s_base, s_term;
  logic          s_trdy, s_ov, s_ovf, s_busy;
  logic [63:0]   s_sum;

  xpb_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .base_in(base_in),
    .term_valid(term_valid), .term_ready(term_ready), .term_in(term_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .overflow(overflow), .busy(busy)
  );

  xpb_accumulator #(.WIDTH(64), .GUARD(0), .NUM_TERMS(8), .CHUNK(64)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .base_in(s_base),
    .term_valid(s_tv), .term_ready(s_trdy), .term_in(s_term),
    .out_valid(s_ov), .out_ready(s_ordy), .sum_out(s_sum),
    .overflow(s_ovf), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  terms [8];
  logic [W-1:0]  ones;
  logic [W-1:0]  base_v;
  logic [AW-1:0] exp_sum;
  int            lat;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int w = 0; w < W/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] model_sum(input logic [W-1:0] b);
    logic [AW-1:0] acc;
    acc = AW'(b);
    for (int i = 0; i < 8; i++) acc = acc + AW'(terms[i]);
    return acc;
  endfunction

  // Start, feed the 8 terms with `gap` idle cycles between them, then wait
  // for out_valid. lat counts edges after the start edge.
  task automatic run_big(input logic [W-1:0] b, input int gap, output int l);
    base_in = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      term_in = terms[i];
      term_valid = 1'b1;
      tick();
      l++;
      term_valid = 1'b0;
      if (i < 7) for (int g = 0; g < gap; g++) begin tick(); l++; end
    end
    while (!out_valid && l < 300) begin tick(); l++; end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; term_valid = 1'b0; out_ready = 1'b0;
    base_in = '0; term_in = '0;
    s_start = 1'b0; s_tv = 1'b0; s_ordy = 1'b0; s_base = '0; s_term = '0;
    ones = '1;
    tick(); tick();

    chk("rst_sum", sum_out, '0);
    chk("rst_ovf", AW'(overflow), '0);
    chk("rst_valid", AW'(out_valid), '0);
    chk("rst_busy", AW'(busy), '0);
    chk("rst_tready", AW'(term_ready), '0);
    chk("rst_small_sum", AW'(s_sum), '0);
    rst = 1'b0;
    tick();

    // term_valid alone must not start anything
    term_valid = 1'b1;
    tick();
    term_valid = 1'b0;
    chk("idle_tv_ignored", AW'(busy), '0);

    // base 0, eight ones
    for (int i = 0; i < 8; i++) terms[i] = W'(1);
    run_big('0, 0, lat);
    chk("t1_latency", AW'(lat), AW'(26));
    chk("t1_sum", sum_out, AW'(8));
    chk("t1_ovf", AW'(overflow), '0);
    handshake();
    chk("t1_release", AW'(out_valid), '0);

    // all ones everywhere: 9*(2^1024-1)
    for (int i = 0; i < 8; i++) terms[i] = ones;
    run_big(ones, 0, lat);
    exp_sum = (AW'(ones) << 3) + AW'(ones);
    chk("t2_latency", AW'(lat), AW'(26));
    chk("t2_sum", sum_out, exp_sum);
    chk("t2_ovf", AW'(overflow), '0);
    handshake();

    // random values with 1,0,0 valid pattern: 7 gaps of 2 cycles
    for (int i = 0; i < 8; i++) terms[i] = rand_wide();
    base_v = rand_wide();
    run_big(base_v, 2, lat);
    exp_sum = model_sum(base_v);
    chk("t3_latency", AW'(lat), AW'(40));
    chk("t3_sum", sum_out, exp_sum);
    chk("t3_ovf", AW'(overflow), '0);

    // stall in DONE, poke start and term_valid
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b0;
      start = c[0];
      term_valid = ~c[0];
      term_in = ones;
      tick();
      chk("t4_hold_sum", sum_out, exp_sum);
      chk("t4_hold_valid", AW'(out_valid), AW'(1));
      chk("t4_hold_tready", AW'(term_ready), '0);
    end
    term_valid = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("t4_handshake_valid", AW'(out_valid), '0);
    chk("t4_handshake_start_ignored", AW'(busy), '0);
    tick();
    chk("t4_still_idle", AW'(busy), '0);

    // reset during RESOLVE chunk 3
    for (int i = 0; i < 8; i++) terms[i] = rand_wide();
    base_v = rand_wide();
    base_in = base_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      term_in = terms[i];
      term_valid = 1'b1;
      tick();
    end
    term_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_busy", AW'(busy), '0);
    chk("t5_rst_valid", AW'(out_valid), '0);
    chk("t5_rst_sum", sum_out, '0);
    chk("t5_rst_ovf", AW'(overflow), '0);
    run_big(base_v, 0, lat);
    chk("t5_latency", AW'(lat), AW'(26));
    chk("t5_sum", sum_out, model_sum(base_v));
    handshake();

    // narrow instance: overflow out of a 64-bit accumulator
    s_base = '0;
    s_term = '1;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      s_tv = 1'b1;
      tick();
      lat++;
    end
    s_tv = 1'b0;
    while (!s_ov && lat < 100) begin tick(); lat++; end
    chk("t6_latency", AW'(lat), AW'(10));
    chk("t6_sum", AW'(s_sum), AW'(64'hFFFF_FFFF_FFFF_FFF8));
    chk("t6_ovf", AW'(s_ovf), AW'(1));
    s_ordy = 1'b1;
    tick();
    s_ordy = 1'b0;
    chk("t6_release", AW'(s_busy), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
